// File: rtl/bridge_tx_arbiter.sv
// Two-port frame arbiter feeding the bridge TX MAC byte interface.
// Grants whole frames round-robin, inserts an inter-frame gap, truncates
// frames longer than MAX_BYTES (draining the rest of the frame from the FIFO)
// and keeps per-port frame counters plus a truncation counter.
module bridge_tx_arbiter #(
  parameter int IFG_CYCLES = 12,
  parameter int MAX_BYTES  = 1518,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             req0_avail,
  input  logic [7:0]       req0_data,
  input  logic             req0_last,
  output logic             req0_rd,
  input  logic             req1_avail,
  input  logic [7:0]       req1_data,
  input  logic             req1_last,
  output logic             req1_rd,
  output logic [7:0]       tx_mac_data,
  output logic             tx_mac_valid,
  output logic             tx_mac_last,
  input  logic             tx_mac_ready,
  output logic [1:0]       grant,
  output logic             busy,
  output logic [CNT_W-1:0] frames0,
  output logic [CNT_W-1:0] frames1,
  output logic [CNT_W-1:0] trunc_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_GAP   = 2'd3;

  localparam int BC_W = $clog2(MAX_BYTES + 1);
  localparam int GC_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(MAX_BYTES - 1);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(IFG_CYCLES - 1);

  logic [1:0]      state;
  logic [1:0]      grant_r;
  logic            last_served;  // port that completed the most recent frame
  logic [BC_W-1:0] byte_cnt;
  logic [GC_W-1:0] gap_cnt;

  logic       sel1;
  logic [7:0] cur_data;
  logic       cur_last;
  logic       in_xfer;
  logic       in_drain;
  logic       at_max;
  logic       accept;
  logic       pop;
  logic       pick1;

  // Datapath muxing and handshakes derived from the registered state/grant.
  always_comb begin
    sel1         = grant_r[1];
    cur_data     = sel1 ? req1_data : req0_data;
    cur_last     = sel1 ? req1_last : req0_last;
    in_xfer      = (state == ST_XFER);
    in_drain     = (state == ST_DRAIN);
    at_max       = (byte_cnt == BC_LAST);
    accept       = in_xfer & tx_mac_ready;
    // DRAIN discards the tail of a truncated frame without waiting on the MAC.
    pop          = accept | in_drain;
    req0_rd      = pop & grant_r[0];
    req1_rd      = pop & grant_r[1];
    tx_mac_valid = in_xfer;
    tx_mac_data  = in_xfer ? cur_data : 8'h00;
    tx_mac_last  = in_xfer & (cur_last | at_max);
    grant        = grant_r;
    busy         = (state != ST_IDLE);
    // With both ports requesting, the port that did not finish last wins.
    pick1        = req1_avail & (~req0_avail | ~last_served);
  end

  // Frame sequencing FSM with round-robin pointer, byte/gap timers and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      grant_r     <= 2'b00;
      last_served <= 1'b1;
      byte_cnt    <= '0;
      gap_cnt     <= '0;
      frames0     <= '0;
      frames1     <= '0;
      trunc_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && (req0_avail || req1_avail)) begin
            grant_r  <= pick1 ? 2'b10 : 2'b01;
            byte_cnt <= '0;
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (accept) begin
            if (cur_last) begin
              if (sel1) frames1 <= frames1 + CNT_W'(1);
              else      frames0 <= frames0 + CNT_W'(1);
              last_served <= sel1;
              grant_r     <= 2'b00;
              byte_cnt    <= '0;
              gap_cnt     <= '0;
              state       <= ST_GAP;
            end else if (at_max) begin
              trunc_cnt <= trunc_cnt + CNT_W'(1);
              byte_cnt  <= '0;
              state     <= ST_DRAIN;
            end else begin
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (cur_last) begin
            last_served <= sel1;
            grant_r     <= 2'b00;
            gap_cnt     <= '0;
            state       <= ST_GAP;
          end
        end
        default: begin
          if (gap_cnt == GC_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt + GC_W'(1);
          end
        end
      endcase
    end
  end

endmodule
